// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding/hazard controller: mux select codes,
// FSM state encodings and the pipeline tracker record.
package fwd_pkg;

  localparam int REG_AW_DEF = 4;

  localparam logic [1:0] FWD_IDEX = 2'b00;
  localparam logic [1:0] FWD_EM   = 2'b10;
  localparam logic [1:0] FWD_MWB  = 2'b01;

  localparam logic RUN      = 1'b0;
  localparam logic MUL_WAIT = 1'b1;

  // One pipeline slot as seen by the controller; valid=0 marks a bubble.
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  we;
    logic                  load;
    logic [REG_AW_DEF-1:0] rs1;
    logic [REG_AW_DEF-1:0] rs2;
    logic                  use_rs2;
  } trk_t;

  localparam int   TRK_W      = $bits(trk_t);
  localparam trk_t TRK_BUBBLE = trk_t'({TRK_W{1'b0}});

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding comparator: picks EM, then MWB, else the IDEX value.
module fwd_sel
  import fwd_pkg::*;
#(
  parameter int AW = REG_AW_DEF
) (
  input  logic          ex_valid,
  input  logic          use_rs,
  input  logic [AW-1:0] rs,
  input  logic          em_valid,
  input  logic          em_we,
  input  logic [AW-1:0] em_rd,
  input  logic          wb_valid,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  output logic [1:0]    sel
);

  localparam logic [AW-1:0] R0 = {AW{1'b0}};

  // R0 is hardwired zero, so it is never a forwarding candidate.
  always_comb begin
    sel = FWD_IDEX;
    if (ex_valid && use_rs && (rs != R0)) begin
      if (em_valid && em_we && (em_rd == rs)) begin
        sel = FWD_EM;
      end else if (wb_valid && wb_we && (wb_rd == rs)) begin
        sel = FWD_MWB;
      end else begin
        sel = FWD_IDEX;
      end
    end else begin
      sel = FWD_IDEX;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding, load-use stall and branch-flush control for the 16-bit pipeline.
// Optional multi-cycle multiply hold is enabled by defining FWD_MUL_STALL_EN.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_mul,
  input  logic              flush,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              stall,
  output logic              idex_bubble,
  output logic              ex_hold
);

  localparam logic [REG_AW-1:0] R0           = {REG_AW{1'b0}};
  localparam logic [3:0]        MUL_CNT_INIT = 4'(MUL_LAT - 1);

  trk_t t_ex_r;
  trk_t t_em_r;
  trk_t t_wb_r;
  trk_t id_trk_s;
  logic hz_s;
  logic state_s;
  logic mul_hold_s;
  logic unused_trk_s;

  // Pack the ID-stage fields into a tracker record.
  always_comb begin
    id_trk_s         = TRK_BUBBLE;
    id_trk_s.valid   = id_valid;
    id_trk_s.rd      = id_rd;
    id_trk_s.we      = id_we;
    id_trk_s.load    = id_load;
    id_trk_s.rs1     = id_rs1;
    id_trk_s.rs2     = id_rs2;
    id_trk_s.use_rs2 = id_use_rs2;
  end

  // Load-use hazard: the load result is not ready until it reaches MWB.
  always_comb begin
    hz_s = 1'b0;
    if (id_valid && (state_s == RUN) && t_ex_r.valid && t_ex_r.load &&
        t_ex_r.we && (t_ex_r.rd != R0)) begin
      hz_s = (t_ex_r.rd == id_rs1) || (id_use_rs2 && (t_ex_r.rd == id_rs2));
    end else begin
      hz_s = 1'b0;
    end
  end

`ifdef FWD_MUL_STALL_EN
  logic       state_r;
  logic [3:0] mul_cnt_r;

  assign state_s    = state_r;
  assign mul_hold_s = (state_r == MUL_WAIT);

  // Multiply FSM: entered when a valid multiply moves into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RUN;
      mul_cnt_r <= 4'd0;
    end else if (flush) begin
      state_r   <= RUN;
      mul_cnt_r <= 4'd0;
    end else if (mul_hold_s) begin
      mul_cnt_r <= mul_cnt_r - 4'd1;
      state_r   <= (mul_cnt_r == 4'd1) ? RUN : MUL_WAIT;
    end else if (!hz_s && id_valid && id_mul) begin
      state_r   <= MUL_WAIT;
      mul_cnt_r <= MUL_CNT_INIT;
    end else begin
      state_r   <= state_r;
      mul_cnt_r <= mul_cnt_r;
    end
  end
`else
  logic unused_mul_s;

  assign state_s      = RUN;
  assign mul_hold_s   = 1'b0;
  assign unused_mul_s = id_mul ^ (MUL_CNT_INIT == 4'd0);
`endif

  // Control outputs; flush overrides both hazard and multiply hold.
  always_comb begin
    stall       = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    if (flush) begin
      idex_bubble = 1'b1;
    end else if (mul_hold_s) begin
      stall   = 1'b1;
      ex_hold = 1'b1;
    end else if (hz_s) begin
      stall       = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      stall       = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  // Tracker shift register mirroring the IDEX/EM/MWB pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_ex_r <= TRK_BUBBLE;
      t_em_r <= TRK_BUBBLE;
      t_wb_r <= TRK_BUBBLE;
    end else if (flush || hz_s) begin
      t_ex_r <= TRK_BUBBLE;
      t_em_r <= t_ex_r;
      t_wb_r <= t_em_r;
    end else if (mul_hold_s) begin
      t_ex_r <= t_ex_r;
      t_em_r <= TRK_BUBBLE;
      t_wb_r <= t_em_r;
    end else begin
      t_ex_r <= id_trk_s;
      t_em_r <= t_ex_r;
      t_wb_r <= t_em_r;
    end
  end

  assign unused_trk_s = ^{t_em_r.rs1, t_em_r.rs2, t_em_r.use_rs2, t_em_r.load,
                          t_wb_r.rs1, t_wb_r.rs2, t_wb_r.use_rs2, t_wb_r.load};

  fwd_sel #(.AW(REG_AW)) u_sel_a (
    .ex_valid (t_ex_r.valid),
    .use_rs   (1'b1),
    .rs       (t_ex_r.rs1),
    .em_valid (t_em_r.valid),
    .em_we    (t_em_r.we),
    .em_rd    (t_em_r.rd),
    .wb_valid (t_wb_r.valid),
    .wb_we    (t_wb_r.we),
    .wb_rd    (t_wb_r.rd),
    .sel      (ForwardA)
  );

  fwd_sel #(.AW(REG_AW)) u_sel_b (
    .ex_valid (t_ex_r.valid),
    .use_rs   (t_ex_r.use_rs2),
    .rs       (t_ex_r.rs2),
    .em_valid (t_em_r.valid),
    .em_we    (t_em_r.we),
    .em_rd    (t_em_r.rd),
    .wb_valid (t_wb_r.valid),
    .wb_we    (t_wb_r.we),
    .wb_rd    (t_wb_r.rd),
    .sel      (ForwardB)
  );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed table-driven bench for fwd_hazard_ctrl; the multiply-hold sequence
// follows FWD_MUL_STALL_EN.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic       id_use_rs2;
  logic [3:0] id_rd;
  logic       id_we;
  logic       id_load;
  logic       id_mul;
  logic       flush;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       stall;
  logic       idex_bubble;
  logic       ex_hold;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(4), .MUL_LAT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_load     (id_load),
    .id_mul      (id_mul),
    .flush       (flush),
    .ForwardA    (ForwardA),
    .ForwardB    (ForwardB),
    .stall       (stall),
    .idex_bubble (idex_bubble),
    .ex_hold     (ex_hold)
  );

  typedef struct {
    logic       v;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       u2;
    logic [3:0] rd;
    logic       we;
    logic       ld;
    logic       fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       bb;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic u2, input logic [3:0] rd, input logic we,
                              input logic ld, input logic fl, input logic [1:0] fa,
                              input logic [1:0] fb, input logic st, input logic bb);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u2 = u2; r.rd = rd; r.we = we;
    r.ld = ld; r.fl = fl; r.fa = fa; r.fb = fb; r.st = st; r.bb = bb;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic u2, input logic [3:0] rd, input logic we,
                       input logic ld, input logic mul, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs2 = u2; id_rd = rd;
    id_we = we; id_load = ld; id_mul = mul; flush = fl;
  endtask

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  initial begin
    // Each row is one ID-stage cycle; expectations derive from earlier rows.
    vecs[0]  = mk(1'b1, 4'd1, 4'd2, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // ADD R3
    vecs[1]  = mk(1'b1, 4'd3, 4'd4, 1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // SUB R6<-R3,R4
    vecs[2]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0); // SUB in EX: R3 from EM
    vecs[3]  = mk(1'b1, 4'd6, 4'd3, 1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // OR R9<-R6,R3
    vecs[4]  = mk(1'b1, 4'd1, 4'd9, 1'b0, 4'd5,  1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0); // OR in EX: R6 from MWB
    vecs[5]  = mk(1'b1, 4'd0, 4'd0, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // LD in EX, rs2 unused
    vecs[6]  = mk(1'b1, 4'd0, 4'd5, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // XOR R10<-R0,R5
    vecs[7]  = mk(1'b1, 4'd1, 4'd5, 1'b0, 4'd2,  1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0); // R5 in EM and WB: EM wins
    vecs[8]  = mk(1'b1, 4'd2, 4'd4, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1); // load-use on R2
    vecs[9]  = mk(1'b1, 4'd2, 4'd4, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // single stall only
    vecs[10] = mk(1'b0, 4'd0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0); // after the bubble, load is in MWB
    vecs[11] = mk(1'b1, 4'd1, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // LD R0
    vecs[12] = mk(1'b1, 4'd0, 4'd0, 1'b1, 4'd13, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // LD R0 never stalls
    vecs[13] = mk(1'b1, 4'd1, 4'd0, 1'b0, 4'd4,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // LD R4
    vecs[14] = mk(1'b1, 4'd4, 4'd4, 1'b1, 4'd14, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1); // hazard + flush
    vecs[15] = mk(1'b0, 4'd0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // EX must be a bubble
    vecs[16] = mk(1'b1, 4'd1, 4'd2, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // ADD R0<-R1,R2
    vecs[17] = mk(1'b1, 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // SUB R15<-R0,R0
    vecs[18] = mk(1'b0, 4'd0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0); // R0 in EM is not forwarded

    rst_n = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_fa", ForwardA, 2'b00);
    chk("reset_fb", ForwardB, 2'b00);
    chk("reset_stall", {1'b0, stall}, 2'b00);
    chk("reset_bubble", {1'b0, idex_bubble}, 2'b00);
    chk("reset_ex_hold", {1'b0, ex_hold}, 2'b00);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u2, vecs[i].rd,
            vecs[i].we, vecs[i].ld, 1'b0, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("row%0d_fa", i), ForwardA, vecs[i].fa);
      chk($sformatf("row%0d_fb", i), ForwardB, vecs[i].fb);
      chk($sformatf("row%0d_stall", i), {1'b0, stall}, {1'b0, vecs[i].st});
      chk($sformatf("row%0d_bubble", i), {1'b0, idex_bubble}, {1'b0, vecs[i].bb});
      chk($sformatf("row%0d_ex_hold", i), {1'b0, ex_hold}, 2'b00);
    end

    // Reset asserted mid-cycle with ADD R3 in EM and a load-use pending.
    @(posedge clk); #1 drive(1'b1, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 drive(1'b1, 4'd3, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1 drive(1'b1, 4'd5, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("prerst_fa", ForwardA, 2'b10);
    chk("prerst_stall", {1'b0, stall}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_fa", ForwardA, 2'b00);
    chk("midrst_fb", ForwardB, 2'b00);
    chk("midrst_stall", {1'b0, stall}, 2'b00);
    chk("midrst_bubble", {1'b0, idex_bubble}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_stall", {1'b0, stall}, 2'b00);
    chk("postrst_fa", ForwardA, 2'b00);

    // Multiply: MUL R7 then dependent ADD R8<-R7,R0.
    @(posedge clk); #1 drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 drive(1'b1, 4'd1, 4'd2, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mul_id_ex_hold", {1'b0, ex_hold}, 2'b00);
    chk("mul_id_stall", {1'b0, stall}, 2'b00);
    @(posedge clk); #1 drive(1'b1, 4'd7, 4'd0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FWD_MUL_STALL_EN
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("mul_hold%0d_ex_hold", c), {1'b0, ex_hold}, 2'b01);
      chk($sformatf("mul_hold%0d_stall", c), {1'b0, stall}, 2'b01);
      chk($sformatf("mul_hold%0d_bubble", c), {1'b0, idex_bubble}, 2'b00);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mul_last_ex_hold", {1'b0, ex_hold}, 2'b00);
    chk("mul_last_stall", {1'b0, stall}, 2'b00);
    chk("mul_last_fa", ForwardA, 2'b00);
`else
    @(negedge clk);
    chk("mul_ex_ex_hold", {1'b0, ex_hold}, 2'b00);
    chk("mul_ex_stall", {1'b0, stall}, 2'b00);
    chk("mul_ex_fa", ForwardA, 2'b00);
`endif
    @(posedge clk); #1 drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mul_dep_fa", ForwardA, 2'b10);
    chk("mul_dep_ex_hold", {1'b0, ex_hold}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
